// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver for the SNN image loader.
// Each received byte appears on rx_data with a one-cycle trigger pulse.
// Bytes are counted per image, and img_done pulses with the last byte of an image.
// Optional feature macro: UART_RX_FRAME_ERR_EN (stop-bit checking with frame_err).
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned BYTES_PER_IMG = 98
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       trigger,
  output logic       busy,
  output logic       img_done,
  output logic       frame_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BcW  = (BYTES_PER_IMG > 1) ? $clog2(BYTES_PER_IMG) : 1;

  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BcW-1:0]  LastByte = BcW'(BYTES_PER_IMG - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state;
  logic            rx_meta;
  logic            rx_s;
  logic [1:0]      sync_vld;  // marks rx_s as carrying a real pin sample, not the reset value
  logic            armed;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [BcW-1:0]  byte_cnt;
  logic            stop_ok;

  // The stop bit is only checked when the frame-error feature is built in.
`ifdef UART_RX_FRAME_ERR_EN
  assign stop_ok = rx_s;
`else
  assign stop_ok = 1'b1;
`endif

  // Synchroniser, arming, frame FSM, byte counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_vld  <= 2'b00;
      armed     <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_cnt  <= '0;
      rx_data   <= 8'h00;
      trigger   <= 1'b0;
      busy      <= 1'b0;
      img_done  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= RX;
      rx_s      <= rx_meta;
      sync_vld  <= {sync_vld[0], 1'b1};
      trigger   <= 1'b0;
      img_done  <= 1'b0;
      frame_err <= 1'b0;

      // Arm only on a genuine idle-high sample so a line held low through reset
      // cannot start a frame.
      if (sync_vld[1] && rx_s) begin
        armed <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (armed && !rx_s) begin
            state    <= StStart;
            baud_cnt <= HalfLoad;
            busy     <= 1'b1;
          end
        end

        StStart: begin
          if (baud_cnt == '0) begin
            if (!rx_s) begin
              state    <= StData;
              baud_cnt <= FullLoad;
              bit_cnt  <= '0;
            end else begin
              // Start bit vanished before mid-bit: treat as a glitch.
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        StData: begin
          if (baud_cnt == '0) begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= FullLoad;
            if (bit_cnt == 3'd7) begin
              state <= StStop;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        StStop: begin
          if (baud_cnt == '0) begin
            state <= StIdle;
            busy  <= 1'b0;
            if (stop_ok) begin
              rx_data <= shreg;
              trigger <= 1'b1;
              if (byte_cnt == LastByte) begin
                byte_cnt <= '0;
                img_done <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
`ifdef UART_RX_FRAME_ERR_EN
              // Disarm so a held-low break yields a single error.
              frame_err <= 1'b1;
              armed     <= 1'b0;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte (CLKS_PER_BIT=16, BYTES_PER_IMG=4).
// Expected bytes go into a scoreboard queue when a frame is driven; the
// monitor logs every trigger and the main process pops and compares them.
module tb_uart_rx_byte;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Bpi = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX  = 1'b1;
  logic [7:0] rx_data;
  logic       trigger;
  logic       busy;
  logic       img_done;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (Cpb),
    .BYTES_PER_IMG(Bpi)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rx_data  (rx_data),
    .trigger  (trigger),
    .busy     (busy),
    .img_done (img_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       done;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_trig;
    logic       exp_done;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_total = 0;
  int   obs_rd = 0;
  exp_t sb[$];

  // Monitor-owned observation log.
  logic [7:0] obs_data[64];
  logic       obs_done[64];
  int         obs_cyc[64];
  int         obs_wr = 0;
  int         ferr_cnt = 0;
  int         stray_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trigger && obs_wr < 64) begin
      obs_data[obs_wr] <= rx_data;
      obs_done[obs_wr] <= img_done;
      obs_cyc[obs_wr]  <= cyc;
      obs_wr           <= obs_wr + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (img_done && !trigger) stray_done <= stray_done + 1;
  end

  // Advance n clocks, landing 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic done);
    exp_t e;
    e.data = d;
    e.done = done;
    sb.push_back(e);
    exp_total++;
  endtask

  // Wait (bounded) for all expected triggers, then compare every logged one.
  task automatic collect(input int budget);
    int n;
    exp_t e;
    n = 0;
    while (obs_wr < exp_total && n < budget) begin
      tick(1);
      n++;
    end
    if (obs_wr < exp_total) begin
      checks++;
      errors++;
      $display("FAIL trigger_timeout: got %0d triggers expected %0d", obs_wr, exp_total);
    end
    while (obs_rd < obs_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trigger: got data %0h expected no trigger", obs_data[obs_rd]);
      end else begin
        e = sb.pop_front();
        if (obs_data[obs_rd] !== e.data || obs_done[obs_rd] !== e.done) begin
          errors++;
          $display("FAIL byte%0d: got data %0h done %0b expected data %0h done %0b", obs_rd,
                   obs_data[obs_rd], obs_done[obs_rd], e.data, e.done);
        end
      end
      obs_rd++;
    end
    // Anything still expected but never seen is dropped so later checks stay aligned.
    while (sb.size() > 0) void'(sb.pop_front());
    exp_total = obs_wr;
  endtask

  // A bad stop bit is held low for 12 clocks so it is low at the mid-bit sample.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(Cpb);
    end
    if (stop) begin
      RX = 1'b1;
      tick(Cpb);
    end else begin
      RX = 1'b0;
      tick(12);
      RX = 1'b1;
      tick(Cpb - 12);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
  endtask

  vec_t vecs[5];

  initial begin
    int start_cyc;
    int n;
    int base;
    logic [7:0] b3c;

    vecs[0] = '{data: 8'h01, stop: 1'b1, exp_trig: 1'b1, exp_done: 1'b0};
    vecs[1] = '{data: 8'h80, stop: 1'b1, exp_trig: 1'b1, exp_done: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_trig: 1'b1, exp_done: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_trig: 1'b1, exp_done: 1'b1};
    vecs[4] = '{data: 8'h3A, stop: 1'b1, exp_trig: 1'b1, exp_done: 1'b0};

    // Reset values.
    @(posedge clk);
    #1;
    tick(3);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_trigger", 32'(trigger), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_img_done", 32'(img_done), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    tick(6);

    // Single byte with latency from the pin start edge.
    expect_byte(8'hA5, 1'b0);
    start_cyc = cyc + 1;
    send_frame(8'hA5, 1'b1);
    tick(4);
    collect(100);
    if (obs_wr > 0) begin
      checks++;
      // About 9.5 bit times (152) plus synchroniser delay.
      if (obs_cyc[0] - start_cyc < 150 || obs_cyc[0] - start_cyc > 156) begin
        errors++;
        $display("FAIL latency: got %0d cycles expected 150..156", obs_cyc[0] - start_cyc);
      end
    end
    check("busy_after_a5", 32'(busy), 32'h0);

    // Back-to-back image bytes from a fresh count.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_trig) expect_byte(vecs[i].data, vecs[i].exp_done);
      send_frame(vecs[i].data, vecs[i].stop);
    end
    tick(4);
    collect(100);
    check("stray_img_done", 32'(stray_done), 32'h0);

    // Short low glitch: START entered, rejected at mid-bit.
    base = obs_wr;
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    check("glitch_busy_high", 32'(busy), 32'h1);
    n = 0;
    while (busy && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy || n < 4 || n > 12) begin
      errors++;
      $display("FAIL glitch_busy_drop: got busy %0b after %0d cycles expected 0 within 4..12",
               busy, n);
    end
    tick(30);
    check("glitch_no_trigger", 32'(obs_wr - base), 32'h0);

    // Reset during data bit 3 of 0x3C with RX then held low.
    b3c = 8'h3C;
    base = obs_wr;
    RX = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 3; i++) begin
      RX = b3c[i];
      tick(Cpb);
    end
    RX = b3c[3];
    tick(8);
    RX = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(197);
    check("rst_mid_busy", 32'(busy), 32'h0);
    RX = 1'b1;
    tick(30);
    check("rst_mid_no_trigger", 32'(obs_wr - base), 32'h0);
    expect_byte(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    tick(4);
    collect(100);

    // Bad stop bit on 0x55, then a clean byte to show recovery.
    base = obs_wr;
`ifdef UART_RX_FRAME_ERR_EN
    send_frame(8'h55, 1'b0);
    tick(20);
    collect(10);
    check("ferr_no_trigger", 32'(obs_wr - base), 32'h0);
    check("ferr_pulses", 32'(ferr_cnt), 32'h1);
    check("ferr_rx_data_kept", 32'(rx_data), 32'h3C);
    expect_byte(8'h12, 1'b0);
`else
    expect_byte(8'h55, 1'b0);
    send_frame(8'h55, 1'b0);
    tick(20);
    collect(10);
    check("noerr_rx_data", 32'(rx_data), 32'h55);
    check("noerr_ferr_zero", 32'(ferr_cnt), 32'h0);
    expect_byte(8'h12, 1'b0);
`endif
    send_frame(8'h12, 1'b1);
    tick(4);
    collect(100);
    check("final_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
